// File: rtl/addr_ptr_bank_pkg.sv
// Shared types and reset constants for the address pointer bank.
// Reset constants are wide patterns; each user casts them to its own WIDTH.
package addr_ptr_pkg;

  typedef enum logic [1:0] {
    FIELD_BASE  = 2'b00,
    FIELD_LIMIT = 2'b01,
    FIELD_STEP  = 2'b10,
    FIELD_PTR   = 2'b11
  } field_e;

  localparam int unsigned RST_W = 64;

  localparam logic [RST_W-1:0] PTR_RST   = '0;
  localparam logic [RST_W-1:0] BASE_RST  = '0;
  localparam logic [RST_W-1:0] LIMIT_RST = '1;
  localparam logic [RST_W-1:0] STEP_RST  = 64'd1;

endpackage

// File: rtl/addr_ptr_bank_if.sv
// Configuration bus, per-channel strobes and pointer outputs of the pointer bank.
interface addr_ptr_bank_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4
);
  import addr_ptr_pkg::*;

  localparam int unsigned CH_W = $clog2(NCH);

  logic                 Wen;
  logic [CH_W-1:0]      WrCh;
  field_e               WrField;
  logic [WIDTH-1:0]     BusOut;
  logic [NCH-1:0]       Rewind;
  logic [NCH-1:0]       Inc;
  logic [NCH-1:0]       Dec;
  logic [NCH*WIDTH-1:0] dout;
  logic [NCH-1:0]       Wrap;

  modport master (
    output Wen, WrCh, WrField, BusOut, Rewind, Inc, Dec,
    input  dout, Wrap
  );

  modport slave (
    input  Wen, WrCh, WrField, BusOut, Rewind, Inc, Dec,
    output dout, Wrap
  );

endinterface

// File: rtl/addr_ptr_bank_ptr_channel.sv
// One pointer channel: base/limit/step/ptr registers, wrap compare and command priority.
// carry_out_c is the advance-wrap condition only; Dec wraps never cascade.
module ptr_channel
  import addr_ptr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             wen,
  input  field_e           field,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rewind,
  input  logic             inc,
  input  logic             dec,
  input  logic             carry_in,
  output logic [WIDTH-1:0] ptr,
  output logic             wrap_now_c,
  output logic             carry_out_c,
  output logic             Wrap
);

  logic [WIDTH-1:0] base_q, limit_q, step_q;
  logic [WIDTH-1:0] ptr_d, base_d, limit_d, step_d;
  logic [WIDTH:0]   nxt, prv;
  logic             adv;

  assign nxt = {1'b0, ptr} + {1'b0, step_q};
  assign prv = {1'b0, ptr} - {1'b0, step_q};
  assign adv = inc | carry_in;

  // Priority: config write, rewind, advance, dec; Inc+Dec without carry holds.
  always_comb begin
    ptr_d       = ptr;
    base_d      = base_q;
    limit_d     = limit_q;
    step_d      = step_q;
    wrap_now_c  = 1'b0;
    carry_out_c = 1'b0;
    if (wen) begin
      case (field)
        FIELD_BASE: begin
          base_d = wdata;
          ptr_d  = wdata;
        end
        FIELD_LIMIT: limit_d = wdata;
        FIELD_STEP:  step_d  = wdata;
        default:     ptr_d   = wdata;
      endcase
    end else if (rewind) begin
      ptr_d = base_q;
    end else if (inc && dec && !carry_in) begin
      ptr_d = ptr;
    end else if (adv) begin
      if (nxt > {1'b0, limit_q}) begin
        ptr_d       = base_q;
        wrap_now_c  = 1'b1;
        carry_out_c = 1'b1;
      end else begin
        ptr_d = nxt[WIDTH-1:0];
      end
    end else if (dec) begin
      if (prv[WIDTH] || (prv[WIDTH-1:0] < base_q)) begin
        ptr_d      = limit_q;
        wrap_now_c = 1'b1;
      end else begin
        ptr_d = prv[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      ptr     <= WIDTH'(PTR_RST);
      base_q  <= WIDTH'(BASE_RST);
      limit_q <= WIDTH'(LIMIT_RST);
      step_q  <= WIDTH'(STEP_RST);
      Wrap    <= 1'b0;
    end else begin
      ptr     <= ptr_d;
      base_q  <= base_d;
      limit_q <= limit_d;
      step_q  <= step_d;
      Wrap    <= wrap_now_c;
    end
  end

endmodule

// File: rtl/addr_ptr_bank.sv
// Bank of NCH address pointers with optional odometer cascade between neighbours.
module addr_ptr_bank
  import addr_ptr_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NCH     = 4,
  parameter int unsigned CASCADE = 0
) (
  input  logic            Clk,
  input  logic            RST,
  addr_ptr_bank_if.slave  bus
);

  localparam int unsigned CH_W = $clog2(NCH);

  logic [NCH-1:0] wen_ch;
  logic [NCH-1:0] carry_in;
  logic [NCH-1:0] carry_out;
  logic [NCH-1:0] wrap_now;
  logic           unused_bits;

  // The last carry and the raw wrap flags have no consumer at this level.
  assign unused_bits = ^{carry_out, wrap_now};

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign wen_ch[k] = bus.Wen && (bus.WrCh == CH_W'(k));

    if (k == 0) begin : g_c0
      assign carry_in[k] = 1'b0;
    end else if (CASCADE != 0) begin : g_cas
      assign carry_in[k] = carry_out[k-1];
    end else begin : g_nocas
      assign carry_in[k] = 1'b0;
    end

    ptr_channel #(.WIDTH(WIDTH)) u_ch (
      .Clk         (Clk),
      .RST         (RST),
      .wen         (wen_ch[k]),
      .field       (bus.WrField),
      .wdata       (bus.BusOut),
      .rewind      (bus.Rewind[k]),
      .inc         (bus.Inc[k]),
      .dec         (bus.Dec[k]),
      .carry_in    (carry_in[k]),
      .ptr         (bus.dout[k*WIDTH +: WIDTH]),
      .wrap_now_c  (wrap_now[k]),
      .carry_out_c (carry_out[k]),
      .Wrap        (bus.Wrap[k])
    );
  end

endmodule

// File: tb/tb_addr_ptr_bank.sv
// Bench for addr_ptr_bank: a non-cascaded and a cascaded instance share stimulus,
// both are checked against an array-based reference model plus fixed vectors.
module tb_addr_ptr_bank;
  import addr_ptr_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic       Clk, RST;
  logic       wen;
  logic [1:0] wr_ch;
  field_e     wr_field;
  logic [7:0] bus_out;
  logic [3:0] rewind, inc, dec;

  int n_pass, n_total;

  addr_ptr_bank_if #(.WIDTH(W), .NCH(N)) if0 ();
  addr_ptr_bank_if #(.WIDTH(W), .NCH(N)) if1 ();

  assign if0.Wen = wen;     assign if1.Wen = wen;
  assign if0.WrCh = wr_ch;  assign if1.WrCh = wr_ch;
  assign if0.WrField = wr_field; assign if1.WrField = wr_field;
  assign if0.BusOut = bus_out;   assign if1.BusOut = bus_out;
  assign if0.Rewind = rewind; assign if1.Rewind = rewind;
  assign if0.Inc = inc;     assign if1.Inc = inc;
  assign if0.Dec = dec;     assign if1.Dec = dec;

  addr_ptr_bank #(.WIDTH(W), .NCH(N), .CASCADE(0)) dut0 (.Clk(Clk), .RST(RST), .bus(if0));
  addr_ptr_bank #(.WIDTH(W), .NCH(N), .CASCADE(1)) dut1 (.Clk(Clk), .RST(RST), .bus(if1));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: index 0 = no cascade, index 1 = cascade.
  int m_ptr   [2][4];
  int m_base  [2][4];
  int m_limit [2][4];
  int m_step  [2][4];
  bit m_wrap  [2][4];

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++) begin
        m_ptr[d][k] = 0; m_base[d][k] = 0; m_limit[d][k] = 255;
        m_step[d][k] = 1; m_wrap[d][k] = 1'b0;
      end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      bit carry;
      carry = 1'b0;
      for (int k = 0; k < 4; k++) begin
        bit cin;
        int n;
        cin = (d == 1) && carry;
        carry = 1'b0;
        m_wrap[d][k] = 1'b0;
        if (wen && int'(wr_ch) == k) begin
          case (wr_field)
            FIELD_BASE:  begin m_base[d][k] = int'(bus_out); m_ptr[d][k] = int'(bus_out); end
            FIELD_LIMIT: m_limit[d][k] = int'(bus_out);
            FIELD_STEP:  m_step[d][k] = int'(bus_out);
            default:     m_ptr[d][k] = int'(bus_out);
          endcase
        end else if (rewind[k]) begin
          m_ptr[d][k] = m_base[d][k];
        end else if (inc[k] && dec[k] && !cin) begin
          n = 0;
        end else if (inc[k] || cin) begin
          n = m_ptr[d][k] + m_step[d][k];
          if (n > m_limit[d][k]) begin
            m_ptr[d][k] = m_base[d][k]; m_wrap[d][k] = 1'b1; carry = 1'b1;
          end else m_ptr[d][k] = n;
        end else if (dec[k]) begin
          n = m_ptr[d][k] - m_step[d][k];
          if (n < 0 || n < m_base[d][k]) begin
            m_ptr[d][k] = m_limit[d][k]; m_wrap[d][k] = 1'b1;
          end else m_ptr[d][k] = n;
        end
      end
    end
  endtask

  function automatic logic [31:0] model_dout(input int d);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[k*8 +: 8] = 8'(m_ptr[d][k]);
    return v;
  endfunction

  function automatic logic [3:0] model_wrap(input int d);
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = m_wrap[d][k];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_model(input string tag);
    check({tag, " dut0 dout"}, if0.dout, model_dout(0));
    check({tag, " dut0 wrap"}, 32'(if0.Wrap), 32'(model_wrap(0)));
    check({tag, " dut1 dout"}, if1.dout, model_dout(1));
    check({tag, " dut1 wrap"}, 32'(if1.Wrap), 32'(model_wrap(1)));
  endtask

  task automatic idle();
    wen = 1'b0; wr_ch = 2'd0; wr_field = FIELD_BASE; bus_out = 8'h00;
    rewind = 4'h0; inc = 4'h0; dec = 4'h0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    model_reset();
    @(posedge Clk);
    #1;
    RST = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] ch, input field_e f, input logic [7:0] v);
    idle();
    wen = 1'b1; wr_ch = ch; wr_field = f; bus_out = v;
    cycle();
    idle();
  endtask

  typedef struct {
    logic        wen;
    logic [1:0]  ch;
    field_e      fld;
    logic [7:0]  data;
    logic [3:0]  rw, inc, dec;
    logic [31:0] exp_dout;
    logic [3:0]  exp_wrap;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic w, input logic [1:0] c, input field_e f,
                              input logic [7:0] dt, input logic [3:0] r, input logic [3:0] i,
                              input logic [3:0] dc, input logic [31:0] ed, input logic [3:0] ew);
    vec_t v;
    v.wen = w; v.ch = c; v.fld = f; v.data = dt; v.rw = r; v.inc = i; v.dec = dc;
    v.exp_dout = ed; v.exp_wrap = ew;
    return v;
  endfunction

  int wrap_cnt;
  bit saw_ff;

  initial begin
    n_pass = 0; n_total = 0;
    idle();
    RST = 1'b1;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    RST = 1'b0;
    check("reset dout", if0.dout, 32'h0);
    check("reset wrap", 32'(if0.Wrap), 32'h0);
    check_model("reset");

    // Count ch0 to 5, then reset between edges.
    inc = 4'h1;
    repeat (5) cycle();
    check("count to 5", 32'(if0.dout[7:0]), 32'h05);
    idle();
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    check("async reset dut0 dout", if0.dout, 32'h0);
    check("async reset dut1 dout", if1.dout, 32'h0);
    check("async reset wrap", 32'({if1.Wrap, if0.Wrap}), 32'h0);
    RST = 1'b0;
    #1;
    inc = 4'h1;
    cycle();
    check("first inc after reset", 32'(if0.dout[7:0]), 32'h01);
    idle();

    // Vector table, expectations for the non-cascaded instance.
    do_reset();
    vecs.push_back(mk(1, 0, FIELD_BASE,  8'h10, 0, 0, 0, 32'h00000010, 4'h0));
    vecs.push_back(mk(1, 0, FIELD_LIMIT, 8'h13, 0, 0, 0, 32'h00000010, 4'h0));
    vecs.push_back(mk(1, 0, FIELD_STEP,  8'h01, 0, 0, 0, 32'h00000010, 4'h0));
    vecs.push_back(mk(0, 0, FIELD_BASE,  8'h00, 0, 1, 0, 32'h00000011, 4'h0));
    vecs.push_back(mk(0, 0, FIELD_BASE,  8'h00, 0, 1, 0, 32'h00000012, 4'h0));
    vecs.push_back(mk(0, 0, FIELD_BASE,  8'h00, 0, 1, 0, 32'h00000013, 4'h0));
    vecs.push_back(mk(0, 0, FIELD_BASE,  8'h00, 0, 1, 0, 32'h00000010, 4'h1));
    vecs.push_back(mk(0, 0, FIELD_BASE,  8'h00, 0, 1, 0, 32'h00000011, 4'h0));
    vecs.push_back(mk(1, 0, FIELD_BASE,  8'h00, 0, 0, 0, 32'h00000000, 4'h0));
    vecs.push_back(mk(1, 0, FIELD_LIMIT, 8'h0A, 0, 0, 0, 32'h00000000, 4'h0));
    vecs.push_back(mk(1, 0, FIELD_STEP,  8'h04, 0, 0, 0, 32'h00000000, 4'h0));
    vecs.push_back(mk(0, 0, FIELD_BASE,  8'h00, 0, 1, 0, 32'h00000004, 4'h0));
    vecs.push_back(mk(0, 0, FIELD_BASE,  8'h00, 0, 1, 0, 32'h00000008, 4'h0));
    vecs.push_back(mk(0, 0, FIELD_BASE,  8'h00, 0, 1, 0, 32'h00000000, 4'h1));
    vecs.push_back(mk(0, 0, FIELD_BASE,  8'h00, 0, 1, 0, 32'h00000004, 4'h0));
    vecs.push_back(mk(0, 0, FIELD_BASE,  8'h00, 0, 0, 1, 32'h00000000, 4'h0));
    vecs.push_back(mk(0, 0, FIELD_BASE,  8'h00, 0, 0, 1, 32'h0000000A, 4'h1));
    vecs.push_back(mk(0, 0, FIELD_BASE,  8'h00, 0, 4, 4, 32'h0000000A, 4'h0));
    vecs.push_back(mk(0, 0, FIELD_BASE,  8'h00, 0, 4, 0, 32'h0001000A, 4'h0));
    vecs.push_back(mk(0, 0, FIELD_BASE,  8'h00, 4, 4, 0, 32'h0000000A, 4'h0));
    vecs.push_back(mk(1, 1, FIELD_PTR,   8'h55, 0, 3, 0, 32'h00005500, 4'h1));
    vecs.push_back(mk(1, 3, FIELD_STEP,  8'h00, 0, 0, 0, 32'h00005500, 4'h0));
    vecs.push_back(mk(0, 0, FIELD_BASE,  8'h00, 0, 8, 0, 32'h00005500, 4'h0));
    vecs.push_back(mk(0, 0, FIELD_BASE,  8'h00, 0, 0, 8, 32'h00005500, 4'h0));
    vecs.push_back(mk(1, 3, FIELD_STEP,  8'h01, 0, 0, 0, 32'h00005500, 4'h0));
    vecs.push_back(mk(1, 2, FIELD_BASE,  8'h20, 0, 0, 0, 32'h00205500, 4'h0));
    vecs.push_back(mk(1, 2, FIELD_LIMIT, 8'h10, 0, 0, 0, 32'h00205500, 4'h0));
    vecs.push_back(mk(0, 0, FIELD_BASE,  8'h00, 0, 4, 0, 32'h00205500, 4'h4));
    vecs.push_back(mk(0, 0, FIELD_BASE,  8'h00, 0, 4, 0, 32'h00205500, 4'h4));
    vecs.push_back(mk(0, 0, FIELD_BASE,  8'h00, 0, 0, 4, 32'h00105500, 4'h4));
    vecs.push_back(mk(0, 0, FIELD_BASE,  8'h00, 0, 0, 0, 32'h00105500, 4'h0));
    foreach (vecs[i]) begin
      wen = vecs[i].wen; wr_ch = vecs[i].ch; wr_field = vecs[i].fld; bus_out = vecs[i].data;
      rewind = vecs[i].rw; inc = vecs[i].inc; dec = vecs[i].dec;
      cycle();
      check($sformatf("vec%0d dout", i), if0.dout, vecs[i].exp_dout);
      check($sformatf("vec%0d wrap", i), 32'(if0.Wrap), 32'(vecs[i].exp_wrap));
      check_model($sformatf("vec%0d", i));
    end
    idle();

    // Cascade: ch0 limit 2 ripples into ch1 on the same edge.
    do_reset();
    cfg(2'd0, FIELD_LIMIT, 8'h02);
    inc = 4'h1;
    cycle();
    check("cas step1", 32'(if1.dout[15:0]), 32'h0001);
    cycle();
    check("cas step2", 32'(if1.dout[15:0]), 32'h0002);
    cycle();
    check("cas step3", 32'(if1.dout[15:0]), 32'h0100);
    check("cas wrap0", 32'(if1.Wrap), 32'h1);
    repeat (2) cycle();
    inc = 4'h3;
    cycle();
    check("cas inc+carry ch1", 32'(if1.dout[15:8]), 32'h02);
    check("cas inc+carry ch0", 32'(if1.dout[7:0]), 32'h00);
    check("nocas inc ch1", 32'(if0.dout[15:8]), 32'h01);
    check_model("cascade");
    idle();

    // Full-range default counter on ch3.
    do_reset();
    wrap_cnt = 0;
    saw_ff = 1'b0;
    inc = 4'h8;
    for (int i = 0; i < 256; i++) begin
      cycle();
      if (if0.Wrap[3]) wrap_cnt++;
      if (if0.dout[31:24] == 8'hFF) saw_ff = 1'b1;
    end
    check("full range wraps", 32'(wrap_cnt), 32'd1);
    check("full range saw FF", 32'(saw_ff), 32'd1);
    check("full range end", 32'(if0.dout[31:24]), 32'h00);
    check_model("full range");
    idle();

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      wen = ($urandom_range(0, 5) == 0);
      wr_ch = 2'($urandom_range(0, 3));
      wr_field = field_e'($urandom_range(0, 3));
      bus_out = 8'($urandom);
      rewind = ($urandom_range(0, 9) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      inc = 4'($urandom);
      dec = 4'($urandom) & 4'($urandom);
      cycle();
      check_model($sformatf("rand%0d", i));
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
